pe_col_drain: RTL and testbench
===============================

PE_COL_DRAIN -- requirements
Module: pe_col_drain

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- COLS 4: array columns drained.
- INT_BW 5: integer bits of the output fixed-point format.
- FRA_BW 10: fraction bits of the output format.
- MUL_BW 16: output word width, equal to 1+INT_BW+FRA_BW.
- ACC_BW 32: accumulator width, with 2*FRA_BW fraction bits.
- DEPTH 4: output FIFO rows, a power of 2 and at least 2.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- clr_i in 1: synchronous flush of capture state, FIFO and flags.
- col_vld_i in COLS: per-column result strobe, skewed; column c arrives one cycle after column c-1.
- col_dat_i in COLS*ACC_BW: per-column signed accumulator from the array bottom row, o_o of each column.
- row_vld_o out 1: FIFO non-empty.
- row_rdy_i in 1: consumer ready.
- row_dat_o out COLS*MUL_BW: head row, column c at bits [c*MUL_BW +: MUL_BW].
- row_sat_o out 1: head row had at least one saturated column.
- ovf_o out 1: sticky flag, a row was dropped because the FIFO was full.
- err_o out 1: sticky flag, a column strobe hit an already-captured column.
- cnt_o out $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-003 Conversion per column SHALL be:
- If acc > 2^(INT_BW+2*FRA_BW)-1, output 0x7FFF (the maximum positive value) and mark the column saturated.
- If acc < -2^(INT_BW+2*FRA_BW), output 0x8000 (the minimum negative value) and mark the column saturated.
- Otherwise output acc[INT_BW+2*FRA_BW : FRA_BW], which truncates toward negative infinity.

REQ-004 Deskew capture: each column SHALL have a captured-bit and a MUL_BW holding register, loaded on the edge where col_vld_i[c]=1 and the captured-bit is 0.

REQ-005 Row completion: a row SHALL complete on the edge where every column is either already captured or strobing that cycle.
- The complete row, including same-cycle data, SHALL be pushed to the FIFO on that edge.
- All captured-bits SHALL clear on that edge.

REQ-006 Latency SHALL be one cycle: if the last column strobes in cycle t, row_vld_o=1 in cycle t+1, provided the FIFO was empty.

REQ-007 Collision: a strobe on an already-captured column that does not complete a row SHALL set err_o and be ignored, leaving the held value unchanged.

REQ-008 FIFO handshake:
- A pop SHALL occur on an edge with row_vld_o=1 and row_rdy_i=1.
- row_dat_o and row_sat_o SHALL be valid whenever row_vld_o=1 and SHALL stay stable until the pop.
- row_rdy_i with an empty FIFO SHALL be a no-op.

REQ-009 Full FIFO:
- If a push occurs with cnt_o=DEPTH and a pop occurs on the same edge, both SHALL occur and cnt_o SHALL be unchanged.
- If a push occurs with cnt_o=DEPTH and there is no pop, the row SHALL be dropped, ovf_o SHALL set, and the captured-bits SHALL still clear.

REQ-010 An empty FIFO with a simultaneous push and pop attempt SHALL perform only the push; no fall-through is allowed.

REQ-011 Read and write pointers SHALL wrap modulo DEPTH.

REQ-012 clr_i SHALL take priority over all other events on that edge:
- It SHALL clear the captured-bits, the pointers, cnt_o, ovf_o and err_o.
- Strobes arriving in that cycle SHALL be discarded.

REQ-013 ovf_o and err_o SHALL clear only on clr_i or reset.

Reset
REQ-014 While rst_n=0, outputs SHALL be:
- row_vld_o=0, row_sat_o=0, ovf_o=0, err_o=0, cnt_o=0.
- row_dat_o=0, with FIFO storage reset to 0.
- All captured-bits 0.

REQ-015 Reset asserted mid-row SHALL discard the partial row; the first strobes after deassertion start a new row.

Structure
REQ-016 The default widths and the saturation constants (max 0x7FFF, min 0x8000, and the ACC thresholds) SHALL live in the shared pe package alongside the PE typedefs.

REQ-017 The per-column conversion SHALL be one combinational sub-module, pe_acc_sat, instantiated COLS times.
- Its outputs SHALL be the converted word and a saturation flag.
- The same sub-module is reusable by other PE-side truncation logic.

Verification
REQ-018 Skewed strobes, one column per cycle, with accs 0x00000400, 0x00100000, 0xFFF00000, 0x00000000:
- Expected response: row 0x0001, 0x0400, 0xFC00, 0x0000.
- row_sat_o=0.
- row_vld_o rises one cycle after the column-3 strobe.

REQ-019 Saturation, col0=0x7FFFFFFF and col1=0x80000000:
- Expected response: 0x7FFF and 0x8000, with row_sat_o=1.

REQ-020 Overflow: 5 rows pushed with row_rdy_i=0 and DEPTH=4:
- Expected response: cnt_o=4 and ovf_o=1.
- Draining the FIFO returns rows 1 to 4 in order.

REQ-021 Full FIFO with row_rdy_i=1 on the same cycle as a fifth row completes:
- Expected response: no overflow and cnt_o stays 4.

REQ-022 Collision: column 0 strobed twice before column 3 arrives:
- Expected response: err_o=1 and the first column-0 value is retained.

REQ-023 Interruption: rst_n pulsed, or clr_i asserted, after 2 of 4 columns are captured:
- Expected response: no row is produced.
- The next full skewed sequence yields exactly one correct row.

Source files
------------

// File: rtl/pe_col_drain_pkg.sv
// Shared PE definitions: default array/format widths, PE word typedefs and
// the saturation constants used when narrowing accumulators to output words.
package pe_col_drain_pkg;

  // Default geometry and fixed-point format
  localparam int COLS_D   = 4;
  localparam int INT_BW_D = 5;
  localparam int FRA_BW_D = 10;
  localparam int MUL_BW_D = 1 + INT_BW_D + FRA_BW_D;
  localparam int ACC_BW_D = 32;
  localparam int DEPTH_D  = 4;

  // PE datapath word types at the default widths
  typedef logic signed [ACC_BW_D-1:0] pe_acc_t;
  typedef logic signed [MUL_BW_D-1:0] pe_word_t;

  // Largest accumulator value that still fits the output format
  function automatic longint acc_sat_hi(input int int_bw, input int fra_bw);
    return (64'sd1 <<< (int_bw + 2 * fra_bw)) - 64'sd1;
  endfunction

  // Smallest accumulator value that still fits the output format
  function automatic longint acc_sat_lo(input int int_bw, input int fra_bw);
    return -(64'sd1 <<< (int_bw + 2 * fra_bw));
  endfunction

  // Accumulator thresholds and clamp words for the default format
  localparam pe_acc_t  ACC_SAT_HI  = pe_acc_t'(acc_sat_hi(INT_BW_D, FRA_BW_D));
  localparam pe_acc_t  ACC_SAT_LO  = pe_acc_t'(acc_sat_lo(INT_BW_D, FRA_BW_D));
  localparam pe_word_t MUL_SAT_MAX = {1'b0, {(MUL_BW_D-1){1'b1}}};
  localparam pe_word_t MUL_SAT_MIN = {1'b1, {(MUL_BW_D-1){1'b0}}};

endpackage

// File: rtl/pe_col_drain_acc_sat.sv
// pe_acc_sat: narrows one signed accumulator (2*FRA_BW fraction bits) to the
// output fixed-point word, clamping to the format limits and flagging a clamp.
// Purely combinational so it can sit in front of any PE-side register.
module pe_acc_sat
  import pe_col_drain_pkg::*;
#(
  parameter int                       INT_BW  = INT_BW_D,
  parameter int                       FRA_BW  = FRA_BW_D,
  parameter int                       MUL_BW  = MUL_BW_D,
  parameter int                       ACC_BW  = ACC_BW_D,
  parameter logic signed [ACC_BW-1:0] SAT_HI  = ACC_SAT_HI,
  parameter logic signed [ACC_BW-1:0] SAT_LO  = ACC_SAT_LO,
  parameter logic signed [MUL_BW-1:0] OUT_MAX = MUL_SAT_MAX,
  parameter logic signed [MUL_BW-1:0] OUT_MIN = MUL_SAT_MIN
) (
  input  logic signed [ACC_BW-1:0] acc_i,
  output logic signed [MUL_BW-1:0] word_o,
  output logic                     sat_o
);

  // Returns {saturated, word}; in-range values drop the low FRA_BW bits,
  // which truncates toward negative infinity for two's complement.
  function automatic logic [MUL_BW:0] sat_conv(input logic signed [ACC_BW-1:0] acc);
    if (acc > SAT_HI) begin
      return {1'b1, OUT_MAX};
    end
    if (acc < SAT_LO) begin
      return {1'b1, OUT_MIN};
    end
    return {1'b0, acc[INT_BW+2*FRA_BW -: MUL_BW]};
  endfunction

  // Conversion of the single accumulator input
  always_comb begin
    {sat_o, word_o} = sat_conv(acc_i);
  end

endmodule

// File: rtl/pe_col_drain.sv
// pe_col_drain: collects the skewed per-column results leaving the bottom of
// the PE array, realigns them into one row, converts each column to the
// output word format and queues complete rows in a small FIFO.
module pe_col_drain
  import pe_col_drain_pkg::*;
#(
  parameter int COLS   = COLS_D,
  parameter int INT_BW = INT_BW_D,
  parameter int FRA_BW = FRA_BW_D,
  parameter int MUL_BW = MUL_BW_D,
  parameter int ACC_BW = ACC_BW_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic [COLS-1:0]            col_vld_i,
  input  logic [COLS*ACC_BW-1:0]     col_dat_i,
  output logic                       row_vld_o,
  input  logic                       row_rdy_i,
  output logic [COLS*MUL_BW-1:0]     row_dat_o,
  output logic                       row_sat_o,
  output logic                       ovf_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = COLS * MUL_BW;

  localparam logic signed [ACC_BW-1:0] SAT_HI  = ACC_BW'(acc_sat_hi(INT_BW, FRA_BW));
  localparam logic signed [ACC_BW-1:0] SAT_LO  = ACC_BW'(acc_sat_lo(INT_BW, FRA_BW));
  localparam logic signed [MUL_BW-1:0] OUT_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic signed [MUL_BW-1:0] OUT_MIN = {1'b1, {(MUL_BW-1){1'b0}}};

  // Capture stage state: one captured-bit and one held word per column
  logic [COLS-1:0] cap_p0;
  logic [RW-1:0]   hold_p0;
  logic [COLS-1:0] hsat_p0;

  // Converted inputs and the row as it would be pushed this cycle
  logic [RW-1:0]   conv_word;
  logic [COLS-1:0] conv_sat;
  logic [RW-1:0]   row_word;
  logic [COLS-1:0] row_sat_vec;

  logic row_done;
  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // FIFO stage state: each entry is {row saturated, row words}
  logic [RW:0]     mem_p1 [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf_q;
  logic            err_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [ACC_BW-1:0] acc;
    assign acc = col_dat_i[c*ACC_BW +: ACC_BW];

    pe_acc_sat #(
      .INT_BW  (INT_BW),
      .FRA_BW  (FRA_BW),
      .MUL_BW  (MUL_BW),
      .ACC_BW  (ACC_BW),
      .SAT_HI  (SAT_HI),
      .SAT_LO  (SAT_LO),
      .OUT_MAX (OUT_MAX),
      .OUT_MIN (OUT_MIN)
    ) u_sat (
      .acc_i  (acc),
      .word_o (conv_word[c*MUL_BW +: MUL_BW]),
      .sat_o  (conv_sat[c])
    );
  end

  // Row assembly: held value for captured columns, live conversion otherwise
  always_comb begin
    row_word    = '0;
    row_sat_vec = '0;
    for (int c = 0; c < COLS; c++) begin
      if (cap_p0[c]) begin
        row_word[c*MUL_BW +: MUL_BW] = hold_p0[c*MUL_BW +: MUL_BW];
        row_sat_vec[c]               = hsat_p0[c];
      end else begin
        row_word[c*MUL_BW +: MUL_BW] = conv_word[c*MUL_BW +: MUL_BW];
        row_sat_vec[c]               = conv_sat[c];
      end
    end
  end

  // Row completes once every column is either held or arriving now; clr wins.
  // A full FIFO still accepts the row if the head leaves on the same edge.
  always_comb begin
    row_done = &(cap_p0 | col_vld_i);
    full     = (cnt == CW'(DEPTH));
    push     = row_done && !clr_i;
    pop      = row_vld_o && row_rdy_i && !clr_i;
    push_ok  = push && (!full || pop);
    drop     = push && full && !pop;
  end

  // ---- capture stage (p0) ----

  // Captured-bits and the collision flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_p0 <= '0;
      err_q  <= 1'b0;
    end else if (clr_i) begin
      cap_p0 <= '0;
      err_q  <= 1'b0;
    end else if (row_done) begin
      cap_p0 <= '0;
    end else begin
      cap_p0 <= cap_p0 | col_vld_i;
      if (|(col_vld_i & cap_p0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Held words load only into empty slots, so a colliding strobe is ignored
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (col_vld_i[c] && !cap_p0[c]) begin
        hold_p0[c*MUL_BW +: MUL_BW] <= conv_word[c*MUL_BW +: MUL_BW];
        hsat_p0[c]                  <= conv_sat[c];
      end
    end
  end

  // ---- output FIFO stage (p1) ----

  // FIFO storage, pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_p1[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_p1[wr_ptr] <= {|row_sat_vec, row_word};
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Head-of-FIFO outputs
  always_comb begin
    row_vld_o = (cnt != '0);
    row_dat_o = mem_p1[rd_ptr][RW-1:0];
    row_sat_o = mem_p1[rd_ptr][RW];
    cnt_o     = cnt;
    ovf_o     = ovf_q;
    err_o     = err_q;
  end

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: directed scenarios plus a randomized run, all
// checked against a row-level reference model (capture slots + row queue).
module tb_pe_col_drain;

  localparam int COLS   = 4;
  localparam int INT_BW = 5;
  localparam int FRA_BW = 10;
  localparam int MUL_BW = 16;
  localparam int ACC_BW = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clr_i;
  logic [COLS-1:0]        col_vld_i;
  logic [COLS*ACC_BW-1:0] col_dat_i;
  logic                   row_vld_o;
  logic                   row_rdy_i;
  logic [COLS*MUL_BW-1:0] row_dat_o;
  logic                   row_sat_o;
  logic                   ovf_o;
  logic                   err_o;
  logic [CW-1:0]          cnt_o;

  int checks = 0;
  int errors = 0;

  pe_col_drain #(
    .COLS(COLS), .INT_BW(INT_BW), .FRA_BW(FRA_BW),
    .MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .col_vld_i(col_vld_i), .col_dat_i(col_dat_i),
    .row_vld_o(row_vld_o), .row_rdy_i(row_rdy_i),
    .row_dat_o(row_dat_o), .row_sat_o(row_sat_o),
    .ovf_o(ovf_o), .err_o(err_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [COLS*MUL_BW-1:0] dat;
    bit                     sat;
  } row_t;

  row_t              mq[$];
  bit                mcap  [COLS];
  logic [MUL_BW-1:0] mhold [COLS];
  bit                mhsat [COLS];
  bit                movf;
  bit                merr;

  // Accumulator -> {sat, word} from the numeric range rule
  function automatic logic [MUL_BW:0] conv(input logic [ACC_BW-1:0] a);
    longint v;
    v = longint'($signed(a));
    if (v > 64'sd33554431)  return {1'b1, 16'h7FFF};
    if (v < -64'sd33554432) return {1'b1, 16'h8000};
    return {1'b0, 16'(v >>> FRA_BW)};
  endfunction

  function automatic row_t conv_row(input logic [COLS*ACC_BW-1:0] accs);
    row_t r;
    logic [MUL_BW:0] cv;
    r.dat = '0;
    r.sat = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      cv = conv(accs[c*ACC_BW +: ACC_BW]);
      r.dat[c*MUL_BW +: MUL_BW] = cv[MUL_BW-1:0];
      r.sat = r.sat | cv[MUL_BW];
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < COLS; c++) mcap[c] = 1'b0;
    mq.delete();
    movf = 1'b0;
    merr = 1'b0;
  endfunction

  // One clock edge of the model, given the inputs present before the edge
  function automatic void model_step(input logic [COLS-1:0] vld,
                                     input logic [COLS*ACC_BW-1:0] dat,
                                     input logic rdy, input logic clr);
    bit all_in;
    row_t r;
    logic [MUL_BW:0] cv;
    if (clr) begin
      model_clear();
      return;
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    all_in = 1'b1;
    for (int c = 0; c < COLS; c++) if (!mcap[c] && !vld[c]) all_in = 1'b0;
    if (all_in) begin
      r.dat = '0;
      r.sat = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        if (mcap[c]) begin
          r.dat[c*MUL_BW +: MUL_BW] = mhold[c];
          r.sat = r.sat | mhsat[c];
        end else begin
          cv = conv(dat[c*ACC_BW +: ACC_BW]);
          r.dat[c*MUL_BW +: MUL_BW] = cv[MUL_BW-1:0];
          r.sat = r.sat | cv[MUL_BW];
        end
        mcap[c] = 1'b0;
      end
      if (mq.size() < DEPTH) mq.push_back(r);
      else movf = 1'b1;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (vld[c]) begin
          if (mcap[c]) begin
            merr = 1'b1;
          end else begin
            cv = conv(dat[c*ACC_BW +: ACC_BW]);
            mcap[c]  = 1'b1;
            mhold[c] = cv[MUL_BW-1:0];
            mhsat[c] = cv[MUL_BW];
          end
        end
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic cycle(input logic [COLS-1:0] vld, input logic [COLS*ACC_BW-1:0] dat,
                       input logic rdy, input logic clr);
    col_vld_i = vld;
    col_dat_i = dat;
    row_rdy_i = rdy;
    clr_i     = clr;
    model_step(vld, dat, rdy, clr);
    @(posedge clk);
    #1;
    col_vld_i = '0;
    row_rdy_i = 1'b0;
    clr_i     = 1'b0;
  endtask

  // Skewed row: column c strobes in the c-th cycle
  task automatic send_row(input logic [COLS*ACC_BW-1:0] accs, input logic rdy_last);
    for (int c = 0; c < COLS; c++) begin
      cycle(COLS'(1 << c), accs, (c == COLS - 1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  function automatic logic [ACC_BW-1:0] rand_acc();
    logic [31:0] b;
    b = $urandom;
    case ($urandom_range(0, 3))
      0:       return b;
      1:       return {{6{b[25]}}, b[25:0]};
      2: begin
        case (b[1:0])
          2'd0:    return 32'h01FF_FFFF;
          2'd1:    return 32'h0200_0000;
          2'd2:    return 32'hFE00_0000;
          default: return 32'hFDFF_FFFF;
        endcase
      end
      default: return 32'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic logic [COLS*ACC_BW-1:0] rand_accs();
    logic [COLS*ACC_BW-1:0] d;
    for (int c = 0; c < COLS; c++) d[c*ACC_BW +: ACC_BW] = rand_acc();
    return d;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clr_i = 1'b0;
    col_vld_i = '0;
    col_dat_i = '0;
    row_rdy_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (row_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", row_vld_o); end
    checks++; if (row_sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", row_sat_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_o); end
    checks++; if (row_dat_o !== 64'h0) begin errors++; $display("FAIL reset_dat got %h want 0", row_dat_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_skew_basic();
    logic [COLS*ACC_BW-1:0] d;
    d = {32'h0000_0000, 32'hFFF0_0000, 32'h0010_0000, 32'h0000_0400};
    for (int c = 0; c < COLS; c++) begin
      cycle(COLS'(1 << c), d, 1'b0, 1'b0);
      checks++;
      if (row_vld_o !== (c == COLS - 1)) begin
        errors++; $display("FAIL skew_vld col=%0d got %b want %b", c, row_vld_o, (c == COLS - 1));
      end
    end
    checks++; if (row_dat_o !== 64'h0000_FC00_0400_0001) begin errors++; $display("FAIL skew_dat got %h want 0000fc0004000001", row_dat_o); end
    checks++; if (row_sat_o !== 1'b0) begin errors++; $display("FAIL skew_sat got %b want 0", row_sat_o); end
    checks++; if (cnt_o !== 3'd1) begin errors++; $display("FAIL skew_cnt got %0d want 1", cnt_o); end
    cycle('0, '0, 1'b1, 1'b0);
    checks++; if (row_vld_o !== 1'b0) begin errors++; $display("FAIL skew_pop_vld got %b want 0", row_vld_o); end
    checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL skew_pop_cnt got %0d want 0", cnt_o); end
  endtask

  task automatic test_saturation();
    logic [COLS*ACC_BW-1:0] d [3];
    logic [COLS*MUL_BW-1:0] w [3];
    logic                   s [3];
    d[0] = {32'h0, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF};
    w[0] = 64'h0000_0000_8000_7FFF; s[0] = 1'b1;
    d[1] = {32'hFDFF_FFFF, 32'hFE00_0000, 32'h0200_0000, 32'h01FF_FFFF};
    w[1] = 64'h8000_8000_7FFF_7FFF; s[1] = 1'b1;
    d[2] = {32'h0, 32'hFE00_0000, 32'h0, 32'h01FF_FFFF};
    w[2] = 64'h0000_8000_0000_7FFF; s[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_row(d[k], 1'b0);
      checks++; if (row_dat_o !== w[k]) begin errors++; $display("FAIL sat_dat row=%0d got %h want %h", k, row_dat_o, w[k]); end
      checks++; if (row_sat_o !== s[k]) begin errors++; $display("FAIL sat_flag row=%0d got %b want %b", k, row_sat_o, s[k]); end
      cycle('0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [COLS*ACC_BW-1:0] d [5];
    row_t exp;
    for (int k = 0; k < 5; k++) begin
      d[k] = rand_accs();
      send_row(d[k], 1'b0);
    end
    checks++; if (cnt_o !== 3'd4) begin errors++; $display("FAIL ovf_cnt got %0d want 4", cnt_o); end
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_o); end
    for (int k = 0; k < 4; k++) begin
      exp = conv_row(d[k]);
      checks++; if (row_dat_o !== exp.dat) begin errors++; $display("FAIL ovf_drain_dat row=%0d got %h want %h", k, row_dat_o, exp.dat); end
      checks++; if (row_sat_o !== exp.sat) begin errors++; $display("FAIL ovf_drain_sat row=%0d got %b want %b", k, row_sat_o, exp.sat); end
      cycle('0, '0, 1'b1, 1'b0);
    end
    checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL ovf_empty_cnt got %0d want 0", cnt_o); end
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_o); end
    cycle('0, '0, 1'b0, 1'b1);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf_o); end
  endtask

  task automatic test_full_pop();
    logic [COLS*ACC_BW-1:0] d [5];
    row_t exp;
    for (int k = 0; k < 5; k++) begin
      d[k] = rand_accs();
      send_row(d[k], (k == 4));
    end
    checks++; if (cnt_o !== 3'd4) begin errors++; $display("FAIL fullpop_cnt got %0d want 4", cnt_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", ovf_o); end
    for (int k = 1; k < 5; k++) begin
      exp = conv_row(d[k]);
      checks++; if (row_dat_o !== exp.dat) begin errors++; $display("FAIL fullpop_dat row=%0d got %h want %h", k, row_dat_o, exp.dat); end
      cycle('0, '0, 1'b1, 1'b0);
    end
    checks++; if (row_vld_o !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b want 0", row_vld_o); end
  endtask

  task automatic test_collision();
    logic [ACC_BW-1:0] a;
    logic [ACC_BW-1:0] b;
    logic [MUL_BW:0]   ca;
    a = 32'h0000_2C00;
    b = 32'h0000_7400;
    ca = conv(a);
    cycle(4'b0001, {96'h0, a}, 1'b0, 1'b0);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL coll_err_early got %b want 0", err_o); end
    cycle(4'b0001, {96'h0, b}, 1'b0, 1'b0);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL coll_err got %b want 1", err_o); end
    for (int c = 1; c < COLS; c++) cycle(COLS'(1 << c), {96'h0, b}, 1'b0, 1'b0);
    checks++; if (cnt_o !== 3'd1) begin errors++; $display("FAIL coll_cnt got %0d want 1", cnt_o); end
    checks++; if (row_dat_o[15:0] !== ca[MUL_BW-1:0]) begin errors++; $display("FAIL coll_keep got %h want %h", row_dat_o[15:0], ca[MUL_BW-1:0]); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b want 1", err_o); end
    cycle('0, '0, 1'b0, 1'b1);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL coll_clr_err got %b want 0", err_o); end
    checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL coll_clr_cnt got %0d want 0", cnt_o); end
  endtask

  task automatic test_interrupt();
    logic [COLS*ACC_BW-1:0] d;
    row_t exp;
    for (int mode = 0; mode < 2; mode++) begin
      d = rand_accs();
      cycle(4'b0001, d, 1'b0, 1'b0);
      cycle(4'b0010, d, 1'b0, 1'b0);
      if (mode == 0) begin
        rst_n = 1'b0;
        model_clear();
        #2;
        checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL intr_rst_cnt got %0d want 0", cnt_o); end
        #1;
        rst_n = 1'b1;
      end else begin
        cycle(4'b0100, d, 1'b0, 1'b1);
      end
      checks++; if (row_vld_o !== 1'b0) begin errors++; $display("FAIL intr_novld mode=%0d got %b want 0", mode, row_vld_o); end
      d = rand_accs();
      exp = conv_row(d);
      send_row(d, 1'b0);
      cycle('0, '0, 1'b0, 1'b0);
      checks++; if (cnt_o !== 3'd1) begin errors++; $display("FAIL intr_cnt mode=%0d got %0d want 1", mode, cnt_o); end
      checks++; if (row_dat_o !== exp.dat) begin errors++; $display("FAIL intr_dat mode=%0d got %h want %h", mode, row_dat_o, exp.dat); end
      cycle('0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [COLS-1:0] vld;
    logic            rdy;
    logic            clr;
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 2) == 0) ? COLS'($urandom) : COLS'(1 << $urandom_range(0, COLS - 1));
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 59) == 0);
      cycle(vld, rand_accs(), rdy, clr);
      checks++; if (cnt_o !== CW'(mq.size())) begin errors++; $display("FAIL rnd_cnt i=%0d got %0d want %0d", i, cnt_o, mq.size()); end
      checks++; if (row_vld_o !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_vld i=%0d got %b want %b", i, row_vld_o, (mq.size() != 0)); end
      checks++; if (ovf_o !== movf) begin errors++; $display("FAIL rnd_ovf i=%0d got %b want %b", i, ovf_o, movf); end
      checks++; if (err_o !== merr) begin errors++; $display("FAIL rnd_err i=%0d got %b want %b", i, err_o, merr); end
      if (mq.size() != 0) begin
        checks++; if (row_dat_o !== mq[0].dat) begin errors++; $display("FAIL rnd_dat i=%0d got %h want %h", i, row_dat_o, mq[0].dat); end
        checks++; if (row_sat_o !== mq[0].sat) begin errors++; $display("FAIL rnd_sat i=%0d got %b want %b", i, row_sat_o, mq[0].sat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_skew_basic();
    test_saturation();
    test_overflow();
    test_full_pop();
    test_collision();
    test_interrupt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
